// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 encodings
// and the funct3 legality rule used when a request is accepted.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores only come in b/h/w; loads additionally allow the unsigned bu/hu forms.
    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return !(f3 inside {F3_B, F3_H, F3_W});
        return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends sub-word loads, merges sub-word
// stores into a full memory word, and flags misaligned half/word accesses.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word,
    output logic        misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // store_word defaults to the old word so only the addressed lane is replaced.
    always_comb begin
        lane_byte  = word[{offset, 3'b000} +: 8];
        lane_half  = offset[1] ? word[31:16] : word[15:0];
        load_val   = '0;
        store_word = word;
        misaligned = 1'b0;
        case (funct3)
            F3_B: begin
                load_val = {{24{lane_byte[7]}}, lane_byte};
                store_word[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            F3_BU: begin
                load_val = {24'b0, lane_byte};
            end
            F3_H: begin
                load_val   = {{16{lane_half[15]}}, lane_half};
                misaligned = offset[0];
                if (offset[1])
                    store_word[31:16] = wdata[15:0];
                else
                    store_word[15:0] = wdata[15:0];
            end
            F3_HU: begin
                load_val   = {16'b0, lane_half};
                misaligned = offset[0];
            end
            F3_W: begin
                load_val   = word;
                store_word = wdata;
                misaligned = |offset;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front-end for a word-only memory: adds byte/half loads with extension,
// read-modify-write sub-word stores, and fault detection behind a valid/ready handshake.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data
);

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    lsu_state_t  state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic [1:0]  align_offset;
    logic [2:0]  align_funct3;
    logic [31:0] load_val;
    logic [31:0] store_word;
    logic        misaligned;
    logic        req_fault;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wr_en = (state == WRITE);

    // In IDLE the aligner judges the incoming request; afterwards it works on the latched one.
    assign align_offset = (state == IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign align_funct3 = (state == IDLE) ? req_funct3    : funct3_q;

    lsu_align u_align (
        .word       (mem_rd_data),
        .offset     (align_offset),
        .funct3     (align_funct3),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word),
        .misaligned (misaligned)
    );

    assign req_fault = is_illegal(req_we, req_funct3) || misaligned ||
                       (req_addr[31:2] >= WORD_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_wr_data <= '0;
            resp_rdata  <= '0;
            resp_valid  <= 1'b0;
            resp_fault  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q       <= req_we;
                        funct3_q   <= req_funct3;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        resp_rdata <= '0;
                        resp_fault <= req_fault;
                        if (req_fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else if (req_we && req_funct3 == F3_W) begin
                            mem_wr_data <= req_wdata;
                            state       <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        mem_wr_data <= store_word;
                        state       <= WRITE;
                    end else begin
                        resp_rdata <= load_val;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
